fpu_sequencer: RTL and testbench

Issue and sequencing controller in front of the combinational fpu datapath. It accepts one FPU operation at a time from the control unit and drives the fpu select lines from a register. Single-cycle ops (moves, casts, fadd/fsub) complete directly. For fmul/fdiv it arbitrates for the shared integer ALU multiplier/divider, starts it, waits for completion and returns a registered result with a done pulse.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/onehot_check.sv | 17 +
 rtl/fpu_sequencer.sv | 151 +++++++++++++++
 tb/tb_fpu_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/sequencing logic: one-hot op
// indices, op-class helpers, FSM state encoding and ALU op codes.
package fpu_pkg;

    localparam int OP_W    = 10;

    localparam int OP_MVRF = 0;
    localparam int OP_MVFR = 1;
    localparam int OP_CRF  = 2;
    localparam int OP_CFR  = 3;
    localparam int OP_CURF = 4;
    localparam int OP_CUFR = 5;
    localparam int OP_FADD = 6;
    localparam int OP_FSUB = 7;
    localparam int OP_FMUL = 8;
    localparam int OP_FDIV = 9;

    localparam logic ALU_MUL = 1'b0;
    localparam logic ALU_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        REQ   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // True when the op needs the shared integer multiplier/divider.
    function automatic logic is_alu_op(input logic [OP_W-1:0] sel);
        return sel[OP_FMUL] | sel[OP_FDIV];
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Flags a vector that has exactly one bit set.
module onehot_check #(
    parameter int W = 10
) (
    input  logic [W-1:0] vec,
    output logic         valid
);

    logic [W-1:0] vec_m1_s;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    always_comb begin
        vec_m1_s = vec - W'(1);
        valid    = (vec != {W{1'b0}}) && ((vec & vec_m1_s) == {W{1'b0}});
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Issue controller in front of the combinational FPU. Single-cycle ops
// run in EXEC; fmul/fdiv borrow the shared ALU mul/div and wait for it,
// with a bounded wait and abort on lost grant.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [9:0]  select,
    output logic        ready,
    output logic        stall,
    output logic [9:0]  fpu_select,
    input  logic [31:0] fpu_z,
    input  logic        fpu_illegal,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic        alu_start,
    output logic        alu_op,
    input  logic        alu_done,
    output logic [31:0] z,
    output logic        illegal,
    output logic        done
);

    seq_state_t       state_r;
    seq_state_t       state_next_s;
    logic [CNT_W-1:0] count_r;
    logic             sel_valid_s;
    logic             accept_s;
    logic             capture_s;
    logic             abort_s;

    onehot_check #(.W(OP_W)) u_onehot_check (
        .vec   (select),
        .valid (sel_valid_s)
    );

    // Next-state logic plus the capture/abort decisions for the result registers.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (!sel_valid_s) begin
                        abort_s      = 1'b1;
                        state_next_s = DONE;
                    end else if (is_alu_op(select)) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = EXEC;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                capture_s    = 1'b1;
                state_next_s = DONE;
            end
            REQ: begin
                if (alu_gnt) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = REQ;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (alu_done) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else if ((count_r == CNT_W'(WAIT_LIMIT - 1)) || !alu_gnt) begin
                    abort_s      = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and control outputs registered from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= IDLE;
            ready     <= 1'b1;
            stall     <= 1'b0;
            alu_req   <= 1'b0;
            alu_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ready     <= (state_next_s == IDLE);
            stall     <= (state_next_s != IDLE);
            alu_req   <= (state_next_s == REQ) || (state_next_s == ISSUE) ||
                         (state_next_s == WAIT);
            alu_start <= (state_next_s == ISSUE);
            done      <= (state_next_s == DONE);
        end
    end

    // Op latch, wait counter and result registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fpu_select <= 10'd0;
            alu_op     <= ALU_MUL;
            count_r    <= {CNT_W{1'b0}};
            z          <= 32'd0;
            illegal    <= 1'b0;
        end else begin
            if (accept_s) begin
                fpu_select <= sel_valid_s ? select : 10'd0;
                alu_op     <= select[OP_FDIV] ? ALU_DIV : ALU_MUL;
            end else if (state_r == DONE) begin
                fpu_select <= 10'd0;
            end

            if (state_r == ISSUE) begin
                count_r <= {CNT_W{1'b0}};
            end else if (state_r == WAIT) begin
                count_r <= count_r + CNT_W'(1);
            end

            if (capture_s) begin
                z       <= fpu_z;
                illegal <= fpu_illegal;
            end else if (abort_s) begin
                z       <= 32'd0;
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: table of single-cycle/invalid ops run
// back to back, then hand-written ALU-path and reset sequences.
module tb_fpu_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [9:0]  select;
    logic        ready;
    logic        stall;
    logic [9:0]  fpu_select;
    logic [31:0] fpu_z;
    logic        fpu_illegal;
    logic        alu_req;
    logic        alu_gnt;
    logic        alu_start;
    logic        alu_op;
    logic        alu_done;
    logic [31:0] z;
    logic        illegal;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [9:0]  sel;
        logic [31:0] fz;
        logic        fill;
        logic [9:0]  exp_fsel;
        logic [31:0] exp_z;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    fpu_sequencer #(.WAIT_LIMIT(64), .CNT_W(7)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .select      (select),
        .ready       (ready),
        .stall       (stall),
        .fpu_select  (fpu_select),
        .fpu_z       (fpu_z),
        .fpu_illegal (fpu_illegal),
        .alu_req     (alu_req),
        .alu_gnt     (alu_gnt),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_done    (alu_done),
        .z           (z),
        .illegal     (illegal),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ALU-path op with grant held from the start; optional grant drop and done cycle.
    task automatic run_alu(input string nm, input logic [9:0] sel, input int drop_c,
                           input int done_c, input int exp_done, input logic [31:0] exp_z,
                           input logic exp_ill);
        int dc;
        int starts;
        dc = 0;
        starts = 0;
        select = sel; start = 1'b1; alu_gnt = 1'b1; alu_done = 1'b0;
        fpu_z = 32'hFFFF_FFFF; fpu_illegal = 1'b0;
        for (int c = 1; c <= 80 && dc == 0; c++) begin
            step();
            start = 1'b0;
            if (c == 1) chk({nm, " alu_op"}, {31'd0, alu_op}, {31'd0, sel[9]});
            if (alu_start) starts++;
            if (done) begin
                dc = c;
                chk({nm, " alu_req_at_done"}, {31'd0, alu_req}, 32'd0);
            end
            alu_gnt  = (c < drop_c);
            alu_done = (c == done_c);
            fpu_z    = (c == done_c) ? 32'h3F00_0000 : 32'hFFFF_FFFF;
        end
        chk({nm, " done_cycle"}, dc, exp_done);
        chk({nm, " z"}, z, exp_z);
        chk({nm, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        chk({nm, " start_pulses"}, starts, 32'd1);
        alu_gnt = 1'b0; alu_done = 1'b0;
        step();
    endtask

    initial begin
        int lat;
        bit seen;
        bit req_seen;
        int nstart;
        int start_cyc;
        int ndone;
        int done_cyc;
        bit req_gap;

        vecs[0] = '{10'h001, 32'h1234_5678, 1'b0, 10'h001, 32'h1234_5678, 1'b0, 2};
        vecs[1] = '{10'h008, 32'hDEAD_BEEF, 1'b1, 10'h008, 32'hDEAD_BEEF, 1'b1, 2};
        vecs[2] = '{10'h040, 32'h3F80_0000, 1'b0, 10'h040, 32'h3F80_0000, 1'b0, 2};
        vecs[3] = '{10'h003, 32'hFFFF_FFFF, 1'b0, 10'h000, 32'h0000_0000, 1'b1, 1};
        vecs[4] = '{10'h080, 32'hC000_0000, 1'b0, 10'h080, 32'hC000_0000, 1'b0, 2};
        vecs[5] = '{10'h000, 32'hFFFF_FFFF, 1'b0, 10'h000, 32'h0000_0000, 1'b1, 1};

        clr = 1'b1; start = 1'b0; select = 10'd0; fpu_z = 32'd0; fpu_illegal = 1'b0;
        alu_gnt = 1'b0; alu_done = 1'b0;
        #12;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst fpu_select", {22'd0, fpu_select}, 32'd0);
        chk("rst z", z, 32'd0);
        chk("rst illegal", {31'd0, illegal}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst alu_req", {31'd0, alu_req}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Table: each op issued the cycle after the previous done.
        for (int i = 0; i < 6; i++) begin
            select = vecs[i].sel; fpu_z = vecs[i].fz; fpu_illegal = vecs[i].fill;
            start = 1'b1;
            lat = 0; seen = 1'b0; req_seen = 1'b0;
            for (int c = 1; c <= 10 && !seen; c++) begin
                step();
                start = 1'b0;
                if (c == 1) chk($sformatf("v%0d fpu_select", i), {22'd0, fpu_select},
                                {22'd0, vecs[i].exp_fsel});
                if (alu_req) req_seen = 1'b1;
                if (done) begin
                    seen = 1'b1;
                    lat = c;
                end
            end
            chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d z", i), z, vecs[i].exp_z);
            chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
            chk($sformatf("v%0d alu_req", i), {31'd0, req_seen}, 32'd0);
            step();
            chk($sformatf("v%0d ready_after", i), {31'd0, ready}, 32'd1);
            chk($sformatf("v%0d done_pulse", i), {31'd0, done}, 32'd0);
        end

        // fmul: grant withheld 5 cycles, ALU done 4 cycles after start, busy start ignored.
        select = 10'h100; start = 1'b1; alu_gnt = 1'b0; alu_done = 1'b0;
        fpu_z = 32'd0; fpu_illegal = 1'b0;
        nstart = 0; start_cyc = 0; ndone = 0; done_cyc = 0; req_gap = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 1) chk("fmul alu_op", {31'd0, alu_op}, 32'd0);
            if (c == 10) chk("fmul fpu_select", {22'd0, fpu_select}, 32'h100);
            if (c == 12) chk("fmul alu_req_done", {31'd0, alu_req}, 32'd0);
            if (c == 13) chk("fmul ready", {31'd0, ready}, 32'd1);
            if (c == 13) chk("fmul fpu_select_clr", {22'd0, fpu_select}, 32'd0);
            if (c <= 11 && !alu_req) req_gap = 1'b1;
            if (alu_start) begin
                nstart++;
                start_cyc = c;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            start    = (c == 2);
            select   = (c == 2) ? 10'h001 : 10'h100;
            alu_gnt  = (c >= 6 && c <= 12);
            alu_done = (c == 11);
            fpu_z    = (c == 11) ? 32'h4080_0000 : 32'd0;
        end
        chk("fmul req_held", {31'd0, req_gap}, 32'd0);
        chk("fmul start_pulses", nstart, 32'd1);
        chk("fmul start_cycle", start_cyc, 32'd7);
        chk("fmul done_count", ndone, 32'd1);
        chk("fmul done_cycle", done_cyc, 32'd12);
        chk("fmul z", z, 32'h4080_0000);
        chk("fmul illegal", {31'd0, illegal}, 32'd0);

        run_alu("fdiv_timeout", 10'h200, 1000, 0, 67, 32'd0, 1'b1);
        run_alu("fdiv_done_at_limit", 10'h200, 1000, 66, 67, 32'h3F00_0000, 1'b0);
        run_alu("fmul_gnt_drop", 10'h100, 4, 0, 5, 32'd0, 1'b1);

        // Reset during WAIT, then a stray alu_done.
        select = 10'h100; start = 1'b1; alu_gnt = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("clr pre alu_req", {31'd0, alu_req}, 32'd1);
        #2 clr = 1'b1;
        #1;
        chk("clr alu_req", {31'd0, alu_req}, 32'd0);
        chk("clr alu_start", {31'd0, alu_start}, 32'd0);
        chk("clr done", {31'd0, done}, 32'd0);
        chk("clr fpu_select", {22'd0, fpu_select}, 32'd0);
        chk("clr ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        clr = 1'b0;
        step();
        alu_done = 1'b1; fpu_z = 32'hAAAA_5555;
        step();
        alu_done = 1'b0; alu_gnt = 1'b0;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) ndone++;
            step();
        end
        chk("clr stray_done", ndone, 32'd0);
        chk("clr ready_after", {31'd0, ready}, 32'd1);
        chk("clr z", z, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
